// File: rtl/mdu_pkg.sv
// Shared MDU opcode encoding, default latencies
// and the start-decode helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_start(
    input logic [2:0] op
  );
    return op == MD_MULT  || op == MD_MULTU ||
           op == MD_DIV   || op == MD_DIVU;
  endfunction

  function automatic logic is_md_div(
    input logic [2:0] op
  );
    return op == MD_DIV || op == MD_DIVU;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply / divide datapath.
// Zero divisor passes current HI/LO through.
module md_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  md_op_t      opc;
  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        zero;
  logic        ovf;
  logic [31:0] dvsr;
  logic [31:0] squot;
  logic [31:0] srem;
  logic [31:0] uquot;
  logic [31:0] urem;

  assign opc   = md_op_t'(op);
  assign sprod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign uprod = {32'd0, rs} * {32'd0, rt};

  // Dividing by 1 yields the overflow result
  // (0x80000000, rem 0) with no special muxing.
  assign zero  = rt == 32'd0;
  assign ovf   = rs == 32'h8000_0000 &&
                 rt == 32'hFFFF_FFFF;
  assign dvsr  = (zero || ovf) ? 32'd1 : rt;

  assign squot = $signed(rs) / $signed(dvsr);
  assign srem  = $signed(rs) % $signed(dvsr);
  assign uquot = rs / dvsr;
  assign urem  = rs % dvsr;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    unique case (1'b1)
      opc == MD_MULT:
        {res_hi, res_lo} = sprod;
      opc == MD_MULTU:
        {res_hi, res_lo} = uprod;
      opc == MD_DIV && !zero: begin
        res_hi = srem;
        res_lo = squot;
      end
      opc == MD_DIVU && !zero: begin
        res_hi = urem;
        res_lo = uquot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// MDU sequencer: HI/LO ownership, latency
// countdown and D/E pipeline stall.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_md_use,
  output logic [31:0] M_hi,
  output logic [31:0] M_lo,
  output logic        busy,
  output logic        stall
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic [CW-1:0] cnt;
  logic          start;

  assign start = is_md_start(E_md_op);
  assign stall = D_md_use & (busy | start);
  assign M_hi  = hi;
  assign M_lo  = lo;

  md_arith u_arith (
    .op     (E_md_op),
    .rs     (E_rs),
    .rt     (E_rt),
    .hi     (hi),
    .lo     (lo),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Ops arriving while busy are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (busy) begin
      if (cnt == ONE) begin
        cnt  <= '0;
        busy <= 1'b0;
        hi   <= pend_hi;
        lo   <= pend_lo;
      end else begin
        cnt <= cnt - ONE;
      end
    end else if (start) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      cnt     <= is_md_div(E_md_op) ? DIV_N : MULT_N;
      busy    <= 1'b1;
    end else if (E_md_op == MD_MTHI) begin
      hi <= E_rs;
    end else if (E_md_op == MD_MTLO) begin
      lo <= E_rs;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: latency,
// results, stall window and async reset.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  E_md_op = 3'd0;
  logic [31:0] E_rs = '0;
  logic [31:0] E_rt = '0;
  logic        D_md_use = 1'b0;
  logic [31:0] M_hi;
  logic [31:0] M_lo;
  logic        busy;
  logic        stall;

  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];

  mdu_seq dut (
    .clk      (clk),
    .reset    (reset),
    .E_md_op  (E_md_op),
    .E_rs     (E_rs),
    .E_rt     (E_rt),
    .D_md_use (D_md_use),
    .M_hi     (M_hi),
    .M_lo     (M_lo),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic issue(
    input logic [2:0]  op,
    input logic [31:0] rs,
    input logic [31:0] rt
  );
    @(negedge clk);
    E_md_op = op;
    E_rs = rs;
    E_rt = rt;
    @(posedge clk);
    #1;
    E_md_op = 3'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    D_md_use = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({M_hi, M_lo, busy, stall} !== '0) begin
      bad++;
      $display("FAIL reset_hold got=%h/%h b=%b s=%b want=0",
               M_hi, M_lo, busy, stall);
    end
    reset = 1'b1;
    D_md_use = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({M_hi, M_lo, busy} !== '0) begin
      bad++;
      $display("FAIL reset_rel got=%h/%h b=%b want=0",
               M_hi, M_lo, busy);
    end
  endtask

  task automatic test_mult;
    logic [63:0] exp;
    logic [31:0] a, b;
    int c;
    sb.push_back(64'hFFFFFFFF_FFFFFFFA);
    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    total++;
    if (busy !== 1'b1 || M_lo !== 32'd0) begin
      bad++;
      $display("FAIL mult_start got b=%b lo=%h want b=1 lo=0",
               busy, M_lo);
    end
    wait_idle(c);
    total++;
    if (c !== 5) begin
      bad++;
      $display("FAIL mult_lat got=%0d want=5", c);
    end
    exp = sb.pop_front();
    total++;
    if ({M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL mult_res got=%h%h want=%h",
               M_hi, M_lo, exp);
    end
    sb.push_back(64'h00000002_FFFFFFFA);
    issue(MD_MULTU, 32'hFFFFFFFE, 32'd3);
    wait_idle(c);
    exp = sb.pop_front();
    total++;
    if (c !== 5 || {M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL multu_res got=%h%h c=%0d want=%h c=5",
               M_hi, M_lo, c, exp);
    end
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      sb.push_back({32'd0, a} * {32'd0, b});
      issue(MD_MULTU, a, b);
      wait_idle(c);
      exp = sb.pop_front();
      total++;
      if ({M_hi, M_lo} !== exp) begin
        bad++;
        $display("FAIL multu_rand got=%h%h want=%h",
                 M_hi, M_lo, exp);
      end
    end
  endtask

  task automatic test_div;
    logic [63:0] exp;
    logic [31:0] a, b;
    int c;
    sb.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(c);
    total++;
    if (c !== 10) begin
      bad++;
      $display("FAIL div_lat got=%0d want=10", c);
    end
    exp = sb.pop_front();
    total++;
    if ({M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL div_res got=%h%h want=%h",
               M_hi, M_lo, exp);
    end
    sb.push_back(64'h00000001_00000003);
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle(c);
    exp = sb.pop_front();
    total++;
    if ({M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL divu_res got=%h%h want=%h",
               M_hi, M_lo, exp);
    end
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom_range(1, 70000);
      sb.push_back({a % b, a / b});
      issue(MD_DIVU, a, b);
      wait_idle(c);
      exp = sb.pop_front();
      total++;
      if ({M_hi, M_lo} !== exp) begin
        bad++;
        $display("FAIL divu_rand got=%h%h want=%h",
                 M_hi, M_lo, exp);
      end
    end
  endtask

  task automatic test_div_edge;
    logic [63:0] exp;
    int c;
    issue(MD_MTHI, 32'h1234, 32'd0);
    total++;
    if (M_hi !== 32'h1234 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi got=%h b=%b want=1234 b=0",
               M_hi, busy);
    end
    issue(MD_MTLO, 32'h5678, 32'd0);
    total++;
    if (M_lo !== 32'h5678 || M_hi !== 32'h1234) begin
      bad++;
      $display("FAIL mtlo got=%h/%h want=1234/5678",
               M_hi, M_lo);
    end
    sb.push_back(64'h00001234_00005678);
    issue(MD_DIV, 32'd99, 32'd0);
    wait_idle(c);
    exp = sb.pop_front();
    total++;
    if (c !== 10 || {M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL div_zero got=%h%h c=%0d want=%h c=10",
               M_hi, M_lo, c, exp);
    end
    sb.push_back(64'h00000000_80000000);
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(c);
    exp = sb.pop_front();
    total++;
    if ({M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL div_ovf got=%h%h want=%h",
               M_hi, M_lo, exp);
    end
  endtask

  task automatic test_stall;
    logic [63:0] exp;
    int n;
    n = 0;
    sb.push_back(64'h00000001_00000000);
    @(negedge clk);
    E_md_op = MD_MULT;
    E_rs = 32'h10000;
    E_rt = 32'h10000;
    D_md_use = 1'b1;
    #1;
    while (stall && n < 30) begin
      n++;
      @(posedge clk);
      #1;
      E_md_op = 3'd0;
      @(negedge clk);
    end
    total++;
    if (n !== 6) begin
      bad++;
      $display("FAIL stall_len got=%0d want=6", n);
    end
    exp = sb.pop_front();
    total++;
    if ({M_hi, M_lo} !== exp || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_res got=%h%h b=%b want=%h b=0",
               M_hi, M_lo, busy, exp);
    end
    D_md_use = 1'b0;
  endtask

  task automatic test_no_stall;
    logic [63:0] exp;
    logic [31:0] h0;
    int c;
    int seen;
    c = 0;
    seen = 0;
    sb.push_back(64'h00000002_0000000E);
    issue(MD_DIVU, 32'd100, 32'd7);
    while (busy && c < 40) begin
      @(negedge clk);
      if (stall) seen++;
      @(posedge clk);
      #1;
      c++;
    end
    total++;
    if (seen !== 0 || c !== 10) begin
      bad++;
      $display("FAIL nostall got=%0d c=%0d want=0 c=10",
               seen, c);
    end
    exp = sb.pop_front();
    total++;
    if ({M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL nostall_res got=%h%h want=%h",
               M_hi, M_lo, exp);
    end
    h0 = M_hi;
    @(negedge clk);
    D_md_use = 1'b1;
    E_md_op = 3'd7;
    E_rs = 32'hDEAD;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_rsvd got=%b want=0", stall);
    end
    @(posedge clk);
    #1;
    E_md_op = 3'd0;
    total++;
    if (stall !== 1'b0 || busy !== 1'b0 || M_hi !== h0) begin
      bad++;
      $display("FAIL rsvd_idle got s=%b b=%b hi=%h want 0/0/%h",
               stall, busy, M_hi, h0);
    end
    D_md_use = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    int c;
    sb.push_back(64'h00000000_00000015);
    sb.push_back(64'h00000000_00000005);
    issue(MD_MULTU, 32'd3, 32'd7);
    wait_idle(c);
    exp = sb.pop_front();
    total++;
    if ({M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL b2b_first got=%h%h want=%h",
               M_hi, M_lo, exp);
    end
    issue(MD_DIV, 32'd21, 32'd4);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start got=%b want=1", busy);
    end
    wait_idle(c);
    exp = sb.pop_front();
    total++;
    if (c !== 10 || {M_hi, M_lo} !== 64'h00000001_00000005) begin
      bad++;
      $display("FAIL b2b_second got=%h%h c=%0d want=%h c=10",
               M_hi, M_lo, c, 64'h00000001_00000005);
    end
    total++;
    if (exp !== 64'h00000000_00000005 - 64'h0 ||
        {M_hi, M_lo} !== {32'd1, exp[31:0]}) begin
      bad++;
      $display("FAIL b2b_order got=%h%h want=%h",
               M_hi, M_lo, {32'd1, exp[31:0]});
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] exp;
    int c;
    issue(MD_MTHI, 32'hAAAA, 32'd0);
    issue(MD_MTLO, 32'h5555, 32'd0);
    issue(MD_DIV, 32'd1000, 32'd7);
    repeat (7) @(posedge clk);
    #3;
    D_md_use = 1'b1;
    reset = 1'b0;
    #1;
    total++;
    if ({M_hi, M_lo, busy, stall} !== '0) begin
      bad++;
      $display("FAIL reset_mid got=%h/%h b=%b s=%b want=0",
               M_hi, M_lo, busy, stall);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    D_md_use = 1'b0;
    sb.push_back(64'hFFFFFFFF_FFFFFFFA);
    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(c);
    exp = sb.pop_front();
    total++;
    if (c !== 5 || {M_hi, M_lo} !== exp) begin
      bad++;
      $display("FAIL reset_resume got=%h%h c=%0d want=%h c=5",
               M_hi, M_lo, c, exp);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_stall();
    test_no_stall();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
